// File: rtl/lbp_pkg.sv
// Shared LBP definitions: code/counter widths, bin count and the
// histogram controller state encoding.
package lbp_pkg;

    localparam int LBP_BIN_W = 8;
    localparam int LBP_CNT_W = 14;
    localparam int LBP_NBINS = 256;

    typedef enum logic [2:0] {
        CLEAR   = 3'd0,
        ACCUM   = 3'd1,
        DRAIN   = 3'd2,
        READOUT = 3'd3,
        DONE    = 3'd4
    } lbp_state_e;

endpackage

// File: rtl/lbp_hist_ram.sv
// Histogram bin storage: one write port, one synchronous read port.
// A read that collides with a write to the same address returns the old
// contents. No reset; the owner clears the array explicitly.
module lbp_hist_ram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 14
) (
    input  logic              clk,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] rd_data_q;

    // Write port and registered read port; non-blocking update gives read-old-data.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/lbp_hist.sv
// LBP code histogram: clears 2**BIN_W bins, accumulates one code per cycle
// through a forwarded read-modify-write pipeline, then streams the bins out.
//
// Readout handshake: hist_bin/hist_count are meaningful only while
// hist_valid is high; a bin transfers on a cycle where hist_valid and
// hist_ready are both high; while hist_valid is high and hist_ready is low
// the presented bin and count hold stable, and hist_valid only drops after
// a transfer (or on reset).
module lbp_hist
    import lbp_pkg::*;
#(
    parameter int BIN_W = LBP_BIN_W,
    parameter int CNT_W = LBP_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             lbp_valid,
    input  logic [BIN_W-1:0] lbp_data,
    input  logic [13:0]      lbp_addr,
    input  logic             finish,
    output logic             busy,
    output logic             drop_err,
    output logic             sat_err,
    output logic             hist_valid,
    input  logic             hist_ready,
    output logic [BIN_W-1:0] hist_bin,
    output logic [CNT_W-1:0] hist_count,
    output logic [CNT_W-1:0] pix_total,
    output logic             hist_done,
    output lbp_state_e       dbg_state
);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [BIN_W-1:0] BIN_LAST = '1;

    lbp_state_e       state_q, state_d;
    logic [BIN_W-1:0] clr_idx_q, clr_idx_d;
    logic             drain_q, drain_d;

    // Accumulate pipeline
    logic             s1_valid_q;
    logic [BIN_W-1:0] s1_bin_q;
    logic             fwd_valid_q;
    logic [BIN_W-1:0] fwd_addr_q;
    logic [CNT_W-1:0] fwd_data_q;
    logic [CNT_W-1:0] pix_total_q;
    logic             drop_err_q;
    logic             sat_err_q;

    // Readout prefetch and output hold
    logic [BIN_W:0]   rd_idx_q;
    logic             pend_q;
    logic [BIN_W-1:0] pend_bin_q;
    logic             hist_valid_q;
    logic [BIN_W-1:0] hist_bin_q;
    logic [CNT_W-1:0] hist_count_q;

    // RAM port signals
    logic             ram_wr_en;
    logic [BIN_W-1:0] ram_wr_addr;
    logic [CNT_W-1:0] ram_wr_data;
    logic             ram_rd_en;
    logic [BIN_W-1:0] ram_rd_addr;
    logic [CNT_W-1:0] ram_rd_data;

    logic             accept;
    logic             drop;
    logic [CNT_W-1:0] old_cnt;
    logic             at_max;
    logic [CNT_W-1:0] new_cnt;
    logic             hs;
    logic             load_out;
    logic             issue_rd;

    // The pixel address is carried alongside the code but plays no part in binning.
    logic             addr_unused;
    assign addr_unused = ^lbp_addr;

    assign accept = lbp_valid && (state_q == ACCUM);
    assign drop   = lbp_valid && (state_q != ACCUM);

    // The RAM returned stale data if last cycle's write hit the same bin.
    assign old_cnt = (fwd_valid_q && (fwd_addr_q == s1_bin_q)) ? fwd_data_q : ram_rd_data;
    assign at_max  = (old_cnt == CNT_MAX);
    assign new_cnt = at_max ? old_cnt : old_cnt + CNT_W'(1);

    assign hs       = hist_valid_q && hist_ready;
    assign load_out = pend_q && (!hist_valid_q || hs);
    assign issue_rd = (state_q == READOUT) && !rd_idx_q[BIN_W] && (!pend_q || load_out);

    // RAM port muxing: CLEAR owns the write port, otherwise the S1 stage does.
    always_comb begin
        ram_wr_en   = s1_valid_q;
        ram_wr_addr = s1_bin_q;
        ram_wr_data = new_cnt;
        if (state_q == CLEAR) begin
            ram_wr_en   = 1'b1;
            ram_wr_addr = clr_idx_q;
            ram_wr_data = '0;
        end
        ram_rd_en   = accept || issue_rd;
        ram_rd_addr = accept ? lbp_data : rd_idx_q[BIN_W-1:0];
    end

    lbp_hist_ram #(
        .ADDR_W (BIN_W),
        .DATA_W (CNT_W)
    ) u_ram (
        .clk       (clk),
        .wr_en_i   (ram_wr_en),
        .wr_addr_i (ram_wr_addr),
        .wr_data_i (ram_wr_data),
        .rd_en_i   (ram_rd_en),
        .rd_addr_i (ram_rd_addr),
        .rd_data_o (ram_rd_data)
    );

    // Next-state logic for the frame controller.
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        drain_d   = drain_q;
        case (state_q)
            CLEAR: begin
                clr_idx_d = clr_idx_q + BIN_W'(1);
                if (clr_idx_q == BIN_LAST) begin
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (finish) begin
                    state_d = DRAIN;
                    drain_d = 1'b0;
                end
            end
            DRAIN: begin
                drain_d = 1'b1;
                if (drain_q) begin
                    state_d = READOUT;
                end
            end
            READOUT: begin
                if (hs && (hist_bin_q == BIN_LAST)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
    end

    // Controller state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= CLEAR;
            clr_idx_q <= '0;
            drain_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            drain_q   <= drain_d;
        end
    end

    // Accumulate pipeline, forwarding register, totals and sticky errors.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_bin_q    <= '0;
            fwd_valid_q <= 1'b0;
            fwd_addr_q  <= '0;
            fwd_data_q  <= '0;
            pix_total_q <= '0;
            drop_err_q  <= 1'b0;
            sat_err_q   <= 1'b0;
        end else begin
            s1_valid_q  <= accept;
            s1_bin_q    <= lbp_data;
            fwd_valid_q <= s1_valid_q;
            fwd_addr_q  <= s1_bin_q;
            fwd_data_q  <= new_cnt;
            if (accept && (pix_total_q != CNT_MAX)) begin
                pix_total_q <= pix_total_q + CNT_W'(1);
            end
            if (drop) begin
                drop_err_q <= 1'b1;
            end
            if (s1_valid_q && at_max) begin
                sat_err_q <= 1'b1;
            end
        end
    end

    // Readout: issue reads ahead while the output register can take the data.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_idx_q     <= '0;
            pend_q       <= 1'b0;
            pend_bin_q   <= '0;
            hist_valid_q <= 1'b0;
            hist_bin_q   <= '0;
            hist_count_q <= '0;
        end else begin
            if (issue_rd) begin
                rd_idx_q   <= rd_idx_q + (BIN_W+1)'(1);
                pend_bin_q <= rd_idx_q[BIN_W-1:0];
                pend_q     <= 1'b1;
            end else if (load_out) begin
                pend_q     <= 1'b0;
            end
            if (load_out) begin
                hist_valid_q <= 1'b1;
                hist_bin_q   <= pend_bin_q;
                hist_count_q <= ram_rd_data;
            end else if (hs) begin
                hist_valid_q <= 1'b0;
            end
        end
    end

    // busy is masked while reset is held so every output reads 0 in reset.
    assign busy       = ((state_q == CLEAR) || (state_q == DRAIN) || (state_q == READOUT)) && !reset;
    assign hist_done  = (state_q == DONE);
    assign drop_err   = drop_err_q;
    assign sat_err    = sat_err_q;
    assign pix_total  = pix_total_q;
    assign hist_valid = hist_valid_q;
    assign hist_bin   = hist_bin_q;
    assign hist_count = hist_count_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_lbp_hist.sv
// Bench for lbp_hist: drives code streams, keeps a bin-count reference
// model, and checks the readout stream through an expected queue.
`timescale 1ns/1ps
module tb_lbp_hist;
    import lbp_pkg::*;

    localparam int BW   = LBP_BIN_W;
    localparam int CW   = LBP_CNT_W;
    localparam int NB   = LBP_NBINS;
    localparam int CMAX = (1 << CW) - 1;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          lbp_valid = 1'b0;
    logic [BW-1:0] lbp_data = '0;
    logic [13:0]   lbp_addr = '0;
    logic          finish = 1'b0;
    logic          hist_ready = 1'b0;
    logic          busy, drop_err, sat_err, hist_valid, hist_done;
    logic [BW-1:0] hist_bin;
    logic [CW-1:0] hist_count, pix_total;
    lbp_state_e    dbg_state;

    always #5 clk = ~clk;

    lbp_hist #(.BIN_W(BW), .CNT_W(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .lbp_valid  (lbp_valid),
        .lbp_data   (lbp_data),
        .lbp_addr   (lbp_addr),
        .finish     (finish),
        .busy       (busy),
        .drop_err   (drop_err),
        .sat_err    (sat_err),
        .hist_valid (hist_valid),
        .hist_ready (hist_ready),
        .hist_bin   (hist_bin),
        .hist_count (hist_count),
        .pix_total  (pix_total),
        .hist_done  (hist_done),
        .dbg_state  (dbg_state)
    );

    // ---------------- bookkeeping / model ----------------
    int               errors = 0;
    int               checks = 0;
    logic [BW+CW-1:0] exp_q[$];
    int               model_hist[NB];
    int               model_total;
    bit               model_sat;
    bit               model_drop;
    int               hs_count;
    int               mon_sum;
    bit               ready_random = 1'b0;
    bit               stall_prev = 1'b0;
    logic [BW-1:0]    prev_bin;
    logic [CW-1:0]    prev_count;
    logic [7:0]       img [128][128];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_hit(input int code);
        if (model_hist[code] == CMAX) model_sat = 1'b1;
        else model_hist[code] = model_hist[code] + 1;
        if (model_total < CMAX) model_total = model_total + 1;
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [BW+CW-1:0] e;
        if (reset) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("stall_valid_held", 32'(hist_valid), 1);
                check("stall_bin_held", 32'(hist_bin), 32'(prev_bin));
                check("stall_count_held", 32'(hist_count), 32'(prev_count));
            end
            if (hist_valid && hist_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_bin: got bin %0d, expected no further bins", hist_bin);
                end else begin
                    e = exp_q.pop_front();
                    check("hist_bin", 32'(hist_bin), 32'(e[BW+CW-1:CW]));
                    check("hist_count", 32'(hist_count), 32'(e[CW-1:0]));
                end
                hs_count++;
                mon_sum = mon_sum + int'(hist_count);
            end
            stall_prev = hist_valid && !hist_ready;
            prev_bin   = hist_bin;
            prev_count = hist_count;
        end
    end

    // Readout back-pressure driver.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            hist_ready = ready_random ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input bit inject_drop);
        int n;
        reset = 1'b1;
        lbp_valid = 1'b0;
        finish = 1'b0;
        ready_random = 1'b0;
        exp_q.delete();
        for (int b = 0; b < NB; b++) model_hist[b] = 0;
        model_total = 0;
        model_sat = 1'b0;
        model_drop = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_drop_err", 32'(drop_err), 0);
        check("rst_sat_err", 32'(sat_err), 0);
        check("rst_hist_valid", 32'(hist_valid), 0);
        check("rst_hist_done", 32'(hist_done), 0);
        check("rst_pix_total", 32'(pix_total), 0);
        check("rst_hist_bin", 32'(hist_bin), 0);
        check("rst_hist_count", 32'(hist_count), 0);
        reset = 1'b0;
        n = 0;
        while (n < 300) begin
            @(negedge clk);
            if (!busy) break;
            n++;
            if (inject_drop && n == 10) begin
                lbp_valid = 1'b1;
                lbp_data = BW'($urandom_range(0, NB - 1));
                model_drop = 1'b1;
            end else begin
                lbp_valid = 1'b0;
            end
        end
        lbp_valid = 1'b0;
        check("clear_busy_cycles", n, 256);
        check("clear_drop_err", 32'(drop_err), 32'(model_drop));
        @(posedge clk);
        #1;
    endtask

    task automatic drive_code(input logic [BW-1:0] code, input logic [13:0] addr,
                              input bit fin, input int gap);
        lbp_valid = 1'b1;
        lbp_data = code;
        lbp_addr = addr;
        finish = fin;
        model_hit(int'(code));
        @(posedge clk);
        #1;
        lbp_valid = 1'b0;
        finish = 1'b0;
        if (gap > 0) tick(gap);
    endtask

    task automatic pulse_finish();
        finish = 1'b1;
        @(posedge clk);
        #1;
        finish = 1'b0;
    endtask

    task automatic arm_readout(input bit rand_ready);
        ready_random = rand_ready;
        hs_count = 0;
        mon_sum = 0;
        for (int b = 0; b < NB; b++) exp_q.push_back({BW'(b), CW'(model_hist[b])});
    endtask

    task automatic run_readout(input bit rand_ready);
        int n;
        arm_readout(rand_ready);
        tick(2);
        check("pix_total", 32'(pix_total), model_total);
        n = 0;
        while (!hist_done && n < 4000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!hist_done) begin
            checks++;
            errors++;
            $display("FAIL readout_timeout: hist_done=%0d after %0d cycles, required 1", hist_done, n);
        end
        if (!rand_ready) check("readout_full_rate", 32'(n <= 270), 1);
        check("handshakes", hs_count, NB);
        check("queue_drained", exp_q.size(), 0);
        check("bin_sum", mon_sum, model_total);
        check("done_hist_valid", 32'(hist_valid), 0);
        check("done_busy", 32'(busy), 0);
        check("sat_err", 32'(sat_err), 32'(model_sat));
        check("drop_err", 32'(drop_err), 32'(model_drop));
        ready_random = 1'b0;
    endtask

    task automatic random_frame(input int ncodes);
        logic [BW-1:0] c;
        for (int i = 0; i < ncodes; i++) begin
            if ($urandom_range(0, 1) == 0) c = BW'($urandom_range(0, 3));
            else c = BW'($urandom_range(0, NB - 1));
            drive_code(c, 14'(i), 1'b0, ($urandom_range(0, 3) == 0) ? 1 : 0);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int dy[8];
        int dx[8];
        int n;
        logic [7:0] ctr;
        logic [BW-1:0] code;
        dy = '{-1, -1, -1, 0, 1, 1, 1, 0};
        dx = '{-1, 0, 1, 1, 1, 0, -1, -1};

        // Empty frame, drop during CLEAR, random back-pressure.
        do_reset(1'b1);
        pulse_finish();
        run_readout(1'b1);

        // Five back-to-back 0xFF codes.
        do_reset(1'b0);
        for (int i = 0; i < 5; i++) drive_code(8'hFF, 14'(i), 1'b0, 0);
        pulse_finish();
        run_readout(1'b0);
        check("ff_pix_total_five", 32'(pix_total), 5);

        // Forwarding pattern, last code arrives with finish.
        do_reset(1'b0);
        drive_code(8'd3, 14'd0, 1'b0, 0);
        drive_code(8'd3, 14'd1, 1'b0, 0);
        drive_code(8'd7, 14'd2, 1'b0, 0);
        drive_code(8'd3, 14'd3, 1'b0, 0);
        drive_code(8'd3, 14'd4, 1'b1, 0);
        run_readout(1'b1);

        // Full frame of LBP codes from a random 128x128 image.
        do_reset(1'b0);
        for (int y = 0; y < 128; y++)
            for (int x = 0; x < 128; x++) img[y][x] = 8'($urandom_range(0, 255));
        for (int y = 1; y < 127; y++) begin
            for (int x = 1; x < 127; x++) begin
                ctr = img[y][x];
                code = '0;
                for (int k = 0; k < 8; k++)
                    code[k] = (img[y + dy[k]][x + dx[k]] >= ctr);
                drive_code(code, 14'(y * 128 + x), 1'b0, ($urandom_range(0, 15) == 0) ? 1 : 0);
            end
        end
        pulse_finish();
        run_readout(1'b1);
        check("frame_dut_bin_sum", mon_sum, 15876);

        // Abort a readout with reset at bin 100.
        do_reset(1'b0);
        random_frame(400);
        pulse_finish();
        arm_readout(1'b1);
        n = 0;
        while (!(hist_valid && hist_bin == 8'd100) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        if (!(hist_valid && hist_bin == 8'd100)) begin
            checks++;
            errors++;
            $display("FAIL abort_wait: bin 100 never presented within %0d cycles", n);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort_hist_valid", 32'(hist_valid), 0);
        check("abort_bins_seen", 32'(hs_count >= 100), 1);
        check("abort_pix_total", 32'(pix_total), 0);
        do_reset(1'b0);

        // Next frame after the abort, then DONE-state behaviour.
        random_frame(300);
        pulse_finish();
        run_readout(1'b1);
        lbp_valid = 1'b1;
        lbp_data = BW'($urandom_range(0, NB - 1));
        @(posedge clk);
        #1;
        lbp_valid = 1'b0;
        tick(1);
        check("done_drop_err", 32'(drop_err), 1);
        pulse_finish();
        tick(3);
        check("done_hist_done_held", 32'(hist_done), 1);
        check("done_no_restart", 32'(hist_valid), 0);
        check("done_not_busy", 32'(busy), 0);

        // Saturation of bin 0 and of the total.
        do_reset(1'b0);
        for (int i = 0; i < CMAX + 7; i++) drive_code('0, 14'(i), 1'b0, 0);
        pulse_finish();
        run_readout(1'b0);
        check("sat_pix_total_max", 32'(pix_total), CMAX);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time bound.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
